// File: rtl/frame_draw_pkg.sv
// Shared definitions for the frame draw sequencer and the draw-source mux:
// select codes, FSM state enumeration and the per-frame slot order.
package frame_draw_pkg;

    // Draw-source select codes, shared with the multiplexer
    localparam logic [2:0] EGG1  = 3'b000;
    localparam logic [2:0] EGG2  = 3'b001;
    localparam logic [2:0] EGG3  = 3'b010;
    localparam logic [2:0] BLACK = 3'b011;
    localparam logic [2:0] PLYR  = 3'b100;
    localparam logic [2:0] GOVR  = 3'b110;
    localparam logic [2:0] NONE  = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ERASE_START, ST_ERASE_WAIT,
        ST_EGG1_START,  ST_EGG1_WAIT,
        ST_EGG2_START,  ST_EGG2_WAIT,
        ST_EGG3_START,  ST_EGG3_WAIT,
        ST_PLYR_START,  ST_PLYR_WAIT,
        ST_GOVR_START,  ST_GOVR_WAIT
    } state_e;

    // Drawable objects in frame order; SLOT_DONE terminates the frame
    typedef enum logic [2:0] {
        SLOT_ERASE, SLOT_EGG1, SLOT_EGG2, SLOT_EGG3, SLOT_PLYR, SLOT_GOVR, SLOT_DONE
    } slot_e;

    // Slot that follows cur; disabled eggs are skipped, game-over replaces eggs and player
    function automatic slot_e next_slot(slot_e cur, logic gov, logic [2:0] eggs);
        slot_e r;
        case (cur)
            SLOT_ERASE: r = gov     ? SLOT_GOVR :
                            eggs[0] ? SLOT_EGG1 :
                            eggs[1] ? SLOT_EGG2 :
                            eggs[2] ? SLOT_EGG3 : SLOT_PLYR;
            SLOT_EGG1:  r = eggs[1] ? SLOT_EGG2 :
                            eggs[2] ? SLOT_EGG3 : SLOT_PLYR;
            SLOT_EGG2:  r = eggs[2] ? SLOT_EGG3 : SLOT_PLYR;
            SLOT_EGG3:  r = SLOT_PLYR;
            default:    r = SLOT_DONE;
        endcase
        return r;
    endfunction

    function automatic slot_e state_slot(state_e s);
        slot_e r;
        case (s)
            ST_ERASE_START, ST_ERASE_WAIT: r = SLOT_ERASE;
            ST_EGG1_START,  ST_EGG1_WAIT:  r = SLOT_EGG1;
            ST_EGG2_START,  ST_EGG2_WAIT:  r = SLOT_EGG2;
            ST_EGG3_START,  ST_EGG3_WAIT:  r = SLOT_EGG3;
            ST_PLYR_START,  ST_PLYR_WAIT:  r = SLOT_PLYR;
            ST_GOVR_START,  ST_GOVR_WAIT:  r = SLOT_GOVR;
            default:                       r = SLOT_DONE;
        endcase
        return r;
    endfunction

    function automatic state_e slot_start_state(slot_e s);
        state_e r;
        case (s)
            SLOT_ERASE: r = ST_ERASE_START;
            SLOT_EGG1:  r = ST_EGG1_START;
            SLOT_EGG2:  r = ST_EGG2_START;
            SLOT_EGG3:  r = ST_EGG3_START;
            SLOT_PLYR:  r = ST_PLYR_START;
            SLOT_GOVR:  r = ST_GOVR_START;
            default:    r = ST_IDLE;
        endcase
        return r;
    endfunction

    function automatic state_e slot_wait_state(slot_e s);
        state_e r;
        case (s)
            SLOT_ERASE: r = ST_ERASE_WAIT;
            SLOT_EGG1:  r = ST_EGG1_WAIT;
            SLOT_EGG2:  r = ST_EGG2_WAIT;
            SLOT_EGG3:  r = ST_EGG3_WAIT;
            SLOT_PLYR:  r = ST_PLYR_WAIT;
            SLOT_GOVR:  r = ST_GOVR_WAIT;
            default:    r = ST_IDLE;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] slot_code(slot_e s);
        logic [2:0] r;
        case (s)
            SLOT_ERASE: r = BLACK;
            SLOT_EGG1:  r = EGG1;
            SLOT_EGG2:  r = EGG2;
            SLOT_EGG3:  r = EGG3;
            SLOT_PLYR:  r = PLYR;
            SLOT_GOVR:  r = GOVR;
            default:    r = NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frame_draw_sequencer_if.sv
// Sequencer-side bundle: frame inputs, engine handshake, plot gate and status.
// master = sequencer, slave = engines / frame source / VGA side.
interface frame_draw_sequencer_if;
    import frame_draw_pkg::*;

    logic       frame_tick;
    logic       game_over;
    logic [2:0] egg_en;
    logic       px_valid;
    logic       slot_done;
    logic [2:0] mux_select;
    logic       slot_start;
    logic       plot;
    logic       busy;
    logic [7:0] overrun_cnt;
    logic       wdog_err;

    modport master (
        input  frame_tick, game_over, egg_en, px_valid, slot_done,
        output mux_select, slot_start, plot, busy, overrun_cnt, wdog_err
    );

    modport slave (
        output frame_tick, game_over, egg_en, px_valid, slot_done,
        input  mux_select, slot_start, plot, busy, overrun_cnt, wdog_err
    );
endinterface

// File: rtl/frame_draw_sequencer_tick_tracker.sv
// Pending frame-tick flag plus saturating count of ticks dropped while a
// frame is still being drawn.
module frame_tick_tracker (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       idle,
    output logic       pending,
    output logic [7:0] overrun_cnt
);

    // Pending is consumed whenever the sequencer is idle (it starts a frame then)
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else if (idle) begin
            pending <= 1'b0;
        end else if (frame_tick) begin
            if (!pending)
                pending <= 1'b1;
            else if (overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Frame draw sequencer: steps the draw-source select through erase, eggs,
// player or game-over once per frame, pulsing each engine's start and gating
// plot to the selected engine.
// Optional slot watchdog: define FRAME_SEQ_WATCHDOG_EN.
module frame_draw_sequencer
    import frame_draw_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 32768,
    parameter int unsigned WDOG_W      = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    frame_draw_sequencer_if.master bus
);

    if (64'(WDOG_CYCLES) >= (64'd1 << WDOG_W)) begin : g_wdog_cfg_bad
        $error("WDOG_W too narrow for WDOG_CYCLES");
    end

    state_e     state, state_nx;
    slot_e      cur;
    logic       gov_q;
    logic [2:0] eggs_q;
    logic       pending;
    logic       frame_go;
    logic       wdog_timeout;
    logic [2:0] mux;
    logic       start;
    logic       plot;

    assign cur      = state_slot(state);
    assign frame_go = (state == ST_IDLE) && (bus.frame_tick || pending);

    frame_tick_tracker u_tick (
        .clock       (clock),
        .resetn      (resetn),
        .frame_tick  (bus.frame_tick),
        .idle        (state == ST_IDLE),
        .pending     (pending),
        .overrun_cnt (bus.overrun_cnt)
    );

`ifdef FRAME_SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_err_q;
    logic              in_wait;

    assign in_wait      = (state != ST_IDLE) && (state != slot_start_state(cur));
    assign wdog_timeout = in_wait && !bus.slot_done && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // Every WAIT is preceded by a START, so clearing outside WAIT equals clearing on START
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt <= in_wait ? wdog_cnt + 1'b1 : '0;
            if (wdog_timeout)
                wdog_err_q <= 1'b1;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_timeout = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    // State register; frame inputs latched on the frame-start edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            gov_q  <= 1'b0;
            eggs_q <= '0;
        end else begin
            state <= state_nx;
            if (frame_go) begin
                gov_q  <= bus.game_over;
                eggs_q <= bus.egg_en;
            end
        end
    end

    // Next-state and Moore/plot outputs
    always_comb begin
        state_nx = state;
        mux      = NONE;
        start    = 1'b0;
        plot     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_go)
                    state_nx = ST_ERASE_START;
            end
            ST_ERASE_START, ST_EGG1_START, ST_EGG2_START,
            ST_EGG3_START, ST_PLYR_START, ST_GOVR_START: begin
                mux      = slot_code(cur);
                start    = 1'b1;
                state_nx = slot_wait_state(cur);
            end
            default: begin
                mux  = slot_code(cur);
                plot = bus.px_valid;
                if (bus.slot_done || wdog_timeout)
                    state_nx = slot_start_state(next_slot(cur, gov_q, eggs_q));
            end
        endcase
    end

    assign bus.mux_select = mux;
    assign bus.slot_start = start;
    assign bus.plot       = plot;
    assign bus.busy       = (state != ST_IDLE);

endmodule
